// File: rtl/div8_seq_pkg.sv
// rtl/div8_seq_pkg.sv - shared constants and state encoding for the restoring divider
package div8_seq_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient reported when the divisor is zero
  localparam logic [W_DEF-1:0] ZERO_DIV_Q = '1;

endpackage

// File: rtl/div8_seq_sub8_rb.sv
// rtl/div8_seq_sub8_rb.sv - combinational W-bit ripple-borrow subtractor, D = A - B - Bin
module sub8_rb
  import div8_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic [W-1:0] D,
  output logic         Bout
);

  logic [W:0] b;

  assign b[0] = Bin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign D[i]   = A[i] ^ B[i] ^ b[i];
    assign b[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & b[i]);
  end

  assign Bout = b[W];

endmodule

// File: rtl/div8_seq.sv
// rtl/div8_seq.sv - sequential unsigned restoring divider, one quotient bit per cycle
module div8_seq
  import div8_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = $clog2(W);

  state_t state, state_nxt;

  logic [W-1:0]  r_q, q_q, d_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  t, diff;
  logic          m, borrow, take;

  // Shifted partial remainder; m is the bit that falls off the top
  assign t    = {r_q[W-2:0], q_q[W-1]};
  assign m    = r_q[W-1];
  assign take = m | ~borrow;

  sub8_rb #(.W(W)) u_sub (
    .A    (t),
    .B    (d_q),
    .Bin  (1'b0),
    .D    (diff),
    .Bout (borrow)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == CW'(W - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            r_q <= '0;
            q_q <= dividend;
            d_q <= divisor;
            cnt <= '0;
          end
        end
        RUN: begin
          r_q <= take ? diff : t;
          q_q <= {q_q[W-2:0], take};
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          done <= 1'b1;
          // Only the zero-divisor path reaches DONE with D = 0; Q still holds the dividend
          if (d_q == '0) begin
            quotient  <= W'(ZERO_DIV_Q);
            remainder <= q_q;
            div_zero  <= 1'b1;
          end else begin
            quotient  <= q_q;
            remainder <= r_q;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
